// File: rtl/rv32i_cpu_top_if.sv
// Memory-side bus of the single-cycle RV32I core: a combinational instruction
// fetch port and a combinational data port with per-byte write strobes.
interface rv32i_cpu_top_if;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_rdata;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;

  modport master (
    output i_mem_addr,
    input  i_mem_rdata,
    output d_mem_addr,
    output d_mem_wdata,
    output d_mem_wen,
    input  d_mem_rdata
  );

  modport slave (
    input  i_mem_addr,
    output i_mem_rdata,
    input  d_mem_addr,
    input  d_mem_wdata,
    input  d_mem_wen,
    output d_mem_rdata
  );
endinterface

// File: rtl/rv32i_cpu_top.sv
// Single-cycle RV32I core: PC, 32x32 register file, decode, ALU, branch
// compare and load/store lane handling. One instruction commits per clock.
module rv32i_cpu_top (
  input  logic              clk,
  input  logic              rst_n,
  rv32i_cpu_top_if.master   bus
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'h37,
    OPC_AUIPC  = 7'h17,
    OPC_JAL    = 7'h6F,
    OPC_JALR   = 7'h67,
    OPC_BRANCH = 7'h63,
    OPC_LOAD   = 7'h03,
    OPC_STORE  = 7'h23,
    OPC_OPIMM  = 7'h13,
    OPC_OP     = 7'h33
  } opcode_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, eff_addr;
  logic [31:0] alu_b, alu_res;
  logic        alu_alt;
  logic        br_eq, br_lt, br_ltu;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rd_we;
  logic [31:0] rd_wdata, st_wdata;
  logic [3:0]  st_wen;

  assign instr  = bus.i_mem_rdata;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  // Shared adder: load/store address, and also the JALR target before bit 0 is cleared.
  assign eff_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

  assign br_eq  = (rs1_val == rs2_val);
  assign br_lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign br_ltu = (rs1_val < rs2_val);

  // ALU shared by register-register and register-immediate arithmetic
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    alu_alt = funct7[5] && ((opcode == OPC_OP) || (funct3 == 3'd5));
    case (funct3)
      3'd0:    alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'd1:    alu_res = rs1_val << alu_b[4:0];
      3'd2:    alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'd3:    alu_res = {31'd0, rs1_val < alu_b};
      3'd4:    alu_res = rs1_val ^ alu_b;
      3'd5:    alu_res = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                 : (rs1_val >> alu_b[4:0]);
      3'd6:    alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  // Load lane selection from the word-aligned read data
  always_comb begin
    case (eff_addr[1:0])
      2'd0:    ld_byte = bus.d_mem_rdata[7:0];
      2'd1:    ld_byte = bus.d_mem_rdata[15:8];
      2'd2:    ld_byte = bus.d_mem_rdata[23:16];
      default: ld_byte = bus.d_mem_rdata[31:24];
    endcase
    ld_half = eff_addr[1] ? bus.d_mem_rdata[31:16] : bus.d_mem_rdata[15:0];
  end

  // Decode/execute: next PC, register write-back and store lanes; undefined encodings fall through as NOPs
  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    st_wen   = '0;
    st_wdata = '0;
    case (opcode)
      OPC_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OPC_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 32'd4;
        pc_d     = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'd0) begin
          rd_we    = 1'b1;
          rd_wdata = pc_q + 32'd4;
          pc_d     = {eff_addr[31:1], 1'b0};
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'd0:    if (br_eq)   pc_d = pc_q + imm_b;
          3'd1:    if (!br_eq)  pc_d = pc_q + imm_b;
          3'd4:    if (br_lt)   pc_d = pc_q + imm_b;
          3'd5:    if (!br_lt)  pc_d = pc_q + imm_b;
          3'd6:    if (br_ltu)  pc_d = pc_q + imm_b;
          3'd7:    if (!br_ltu) pc_d = pc_q + imm_b;
          default: pc_d = pc_q + 32'd4;
        endcase
      end
      OPC_LOAD: begin
        rd_we = 1'b1;
        case (funct3)
          3'd0:    rd_wdata = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    rd_wdata = {{16{ld_half[15]}}, ld_half};
          3'd2:    rd_wdata = bus.d_mem_rdata;
          3'd4:    rd_wdata = {24'd0, ld_byte};
          3'd5:    rd_wdata = {16'd0, ld_half};
          default: rd_we    = 1'b0;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'd0: begin
            st_wen   = 4'b0001 << eff_addr[1:0];
            st_wdata = {4{rs2_val[7:0]}};
          end
          3'd1: begin
            st_wen   = eff_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{rs2_val[15:0]}};
          end
          3'd2: begin
            st_wen   = 4'b1111;
            st_wdata = rs2_val;
          end
          default: st_wen = '0;
        endcase
      end
      OPC_OPIMM: begin
        if (funct3 == 3'd1)
          rd_we = (funct7 == 7'h00);
        else if (funct3 == 3'd5)
          rd_we = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
          rd_we = 1'b1;
        rd_wdata = alu_res;
      end
      OPC_OP: begin
        rd_we    = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        rd_wdata = alu_res;
      end
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  // Program counter: returns to 0 on reset, otherwise advances once per clock
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  // Register file: cleared on reset; x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rd_we && (rd != 5'd0)) begin
      rf_q[rd] <= rd_wdata;
    end
  end

  assign bus.i_mem_addr  = pc_q;
  assign bus.d_mem_addr  = rst_n ? eff_addr : '0;
  assign bus.d_mem_wdata = rst_n ? st_wdata : '0;
  assign bus.d_mem_wen   = rst_n ? st_wen   : '0;

endmodule

// File: tb/tb_rv32i_cpu_top.sv
// Directed bench for rv32i_cpu_top: small hand-assembled programs in a local
// instruction memory, results observed through stores and bus activity.
module tb_rv32i_cpu_top;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  rv32i_cpu_top_if bus ();

  rv32i_cpu_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.i_mem_rdata = imem[bus.i_mem_addr[9:2]];
  assign bus.d_mem_rdata = dmem[bus.d_mem_addr[9:2]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++)
      if (bus.d_mem_wen[n])
        dmem[bus.d_mem_addr[9:2]][8*n +: 8] = bus.d_mem_wdata[8*n +: 8];
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int off, int rs1, int rs2, int f3);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int off, int rd);
    return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    return enc_s(imm, rs2, rs1, 2);
  endfunction

  function automatic logic [31:0] rd_mem(int a);
    return dmem[a[9:2]];
  endfunction

  task automatic put(int a, logic [31:0] w);
    imem[a[9:2]] = w;
  endtask
  task automatic wr_mem(int a, logic [31:0] v);
    dmem[a[9:2]] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = NOP;
      dmem[i] = 32'hDEAD_0000 | i;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          br_f3  [8] = '{4, 5, 6, 7, 5, 1, 0, 4};
  int          br_ra  [8] = '{1, 1, 1, 1, 1, 1, 1, 2};
  int          br_rb  [8] = '{2, 2, 2, 2, 1, 2, 2, 1};
  logic [31:0] br_exp [8] = '{1, 0, 0, 1, 1, 1, 0, 0};
  logic [31:0] alu_exp [7] = '{32'hFFFF_FFFC, 32'h0000_000F, 32'h0000_0017,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0007,
                               32'h0000_101C};

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    checks = 0;
    errors = 0;

    // BEQ taken over two writes of x3
    clear_mem();
    put('h00, addi(1, 0, 5));
    put('h04, addi(2, 0, 5));
    put('h08, enc_b(12, 1, 2, 0));
    put('h0C, addi(3, 0, 1));
    put('h10, addi(3, 0, 1));
    put('h14, sw(3, 0, 'h100));
    put('h18, enc_j(0, 0));
    do_reset();
    chk("reset_pc", bus.i_mem_addr, 32'h0);
    run(12);
    chk("beq_taken", rd_mem('h100), 32'h0);

    // BEQ not taken: the skipped writes execute
    put('h04, addi(2, 0, 6));
    do_reset();
    run(12);
    chk("beq_not_taken", rd_mem('h100), 32'h1);

    // Signed/unsigned compares with x1=-1, x2=1, one flag word each
    clear_mem();
    put('h00, addi(1, 0, -1));
    put('h04, addi(2, 0, 1));
    for (int k = 0; k < 8; k++) begin
      put(8 + 16*k,      addi(3, 0, 1));
      put(8 + 16*k + 4,  enc_b(8, br_ra[k], br_rb[k], br_f3[k]));
      put(8 + 16*k + 8,  addi(3, 0, 0));
      put(8 + 16*k + 12, sw(3, 0, 'h110 + 4*k));
    end
    put('h88, enc_j(0, 0));
    do_reset();
    run(45);
    for (int k = 0; k < 8; k++)
      chk($sformatf("branch_flag%0d", k), rd_mem('h110 + 4*k), br_exp[k]);

    // Backward-branch loop counting to 3
    clear_mem();
    put('h00, addi(1, 0, 0));
    put('h04, addi(5, 0, 3));
    put('h08, addi(1, 1, 1));
    put('h0C, enc_b(-4, 1, 5, 1));
    put('h10, sw(1, 0, 'h130));
    put('h14, enc_j(0, 0));
    do_reset();
    run(15);
    chk("loop_count", rd_mem('h130), 32'h3);

    // JAL / JALR sequence, including an odd JALR target with rd == rs1
    clear_mem();
    put('h00, enc_j('h40, 0));
    put('h40, enc_j(8, 1));
    put('h44, enc_j('h1C, 0));
    put('h48, enc_i(0, 1, 0, 0, 'h67));
    put('h60, sw(1, 0, 'h140));
    put('h64, addi(4, 0, 'h81));
    put('h68, enc_i(0, 4, 0, 4, 'h67));
    put('h80, sw(4, 0, 'h144));
    put('h84, enc_j(0, 0));
    do_reset();
    tick();
    chk("jal_to_0x40", bus.i_mem_addr, 32'h40);
    tick();
    chk("jal_plus8", bus.i_mem_addr, 32'h48);
    tick();
    chk("jalr_to_0x44", bus.i_mem_addr, 32'h44);
    tick();
    chk("jal_to_0x60", bus.i_mem_addr, 32'h60);
    chk("jal_link_wdata", bus.d_mem_wdata, 32'h44);
    run(3);
    chk("jalr_odd_pc", bus.i_mem_addr, 32'h80);
    chk("jalr_link_addr", bus.d_mem_addr, 32'h144);
    chk("jalr_link_wen", {28'd0, bus.d_mem_wen}, 32'hF);
    chk("jalr_link_wdata", bus.d_mem_wdata, 32'h6C);
    tick();
    chk("jal_link_mem", rd_mem('h140), 32'h44);

    // Sub-word stores and loads around word 0x200
    clear_mem();
    wr_mem('h200, 32'h1122_3344);
    put('h00, addi(2, 0, 'h80));
    put('h04, addi(3, 0, 'hA5));
    put('h08, enc_u(8, 4, 'h37));
    put('h0C, addi(4, 4, 1));
    put('h10, enc_s('h182, 4, 2, 1));
    put('h14, enc_s('h183, 3, 2, 0));
    put('h18, enc_i('h183, 2, 0, 5, 'h03));
    put('h1C, enc_i('h183, 2, 4, 6, 'h03));
    put('h20, enc_i('h182, 2, 1, 7, 'h03));
    put('h24, enc_i('h182, 2, 5, 8, 'h03));
    put('h28, enc_i('h180, 2, 2, 9, 'h03));
    for (int k = 5; k <= 9; k++) put('h2C + 4*(k-5), sw(k, 2, 'h190 + 4*(k-5)));
    put('h40, enc_j(0, 0));
    do_reset();
    run(4);
    chk("sh_addr", bus.d_mem_addr, 32'h202);
    chk("sh_wen", {28'd0, bus.d_mem_wen}, 32'hC);
    chk("sh_wdata", bus.d_mem_wdata, 32'h8001_8001);
    tick();
    chk("sb_addr", bus.d_mem_addr, 32'h203);
    chk("sb_wen", {28'd0, bus.d_mem_wen}, 32'h8);
    chk("sb_wdata", bus.d_mem_wdata, 32'hA5A5_A5A5);
    run(16);
    chk("subword_word", rd_mem('h200), 32'hA501_3344);
    chk("lb", rd_mem('h210), 32'hFFFF_FFA5);
    chk("lbu", rd_mem('h214), 32'h0000_00A5);
    chk("lh", rd_mem('h218), 32'hFFFF_A501);
    chk("lhu", rd_mem('h21C), 32'h0000_A501);
    chk("lw", rd_mem('h220), 32'hA501_3344);

    // Shifts, compares, SUB, XORI and AUIPC
    clear_mem();
    put('h00, addi(1, 0, -8));
    put('h04, enc_i('h401, 1, 5, 2, 'h13));
    put('h08, enc_i(28, 1, 5, 3, 'h13));
    put('h0C, enc_r('h20, 1, 3, 0, 4));
    put('h10, enc_r(0, 1, 3, 3, 5));
    put('h14, enc_r(0, 1, 3, 2, 6));
    put('h18, enc_i(-1, 1, 4, 7, 'h13));
    put('h1C, enc_u(1, 8, 'h17));
    for (int k = 2; k <= 8; k++) put('h20 + 4*(k-2), sw(k, 0, 'h300 + 4*(k-2)));
    put('h3C, enc_j(0, 0));
    do_reset();
    run(20);
    for (int k = 0; k < 7; k++)
      chk($sformatf("alu_x%0d", k + 2), rd_mem('h300 + 4*k), alu_exp[k]);

    // Store at address 0 held off by reset, then reset mid-program
    clear_mem();
    wr_mem('h108, 32'h5555_5555);
    wr_mem('h10C, 32'h6666_6666);
    put('h00, sw(1, 0, 'h108));
    put('h04, addi(1, 0, 7));
    put('h08, sw(1, 0, 'h10C));
    put('h0C, enc_j(-12, 0));
    rst_n = 1'b0;
    run(2);
    chk("rst_pc", bus.i_mem_addr, 32'h0);
    chk("rst_wen", {28'd0, bus.d_mem_wen}, 32'h0);
    chk("rst_addr", bus.d_mem_addr, 32'h0);
    chk("rst_wdata", bus.d_mem_wdata, 32'h0);
    chk("rst_no_store", rd_mem('h108), 32'h5555_5555);
    rst_n = 1'b1;
    tick();
    chk("first_instr_store", rd_mem('h108), 32'h0);
    chk("first_instr_pc", bus.i_mem_addr, 32'h4);
    tick();
    chk("pre_abort_wdata", bus.d_mem_wdata, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("abort_wen", {28'd0, bus.d_mem_wen}, 32'h0);
    wr_mem('h108, 32'hAAAA_AAAA);
    tick();
    chk("abort_pc", bus.i_mem_addr, 32'h0);
    chk("abort_no_store", rd_mem('h10C), 32'h6666_6666);
    rst_n = 1'b1;
    tick();
    chk("regs_cleared", rd_mem('h108), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
